regfile_writeback_arbiter: RTL and testbench
============================================

Name: regfile_writeback_arbiter

Overview:
Writer side of the 32x32 register file write port (regWrite/writeReg/writeData), which writes on posedge clk and drops writes to r0.
Merges two result sources onto that single port:
- single-cycle ALU results (valid/ready);
- long-latency results, such as loads, buffered in an in-order FIFO.
Exports a pending-register mask so decode can stall on RAW hazards against buffered results.

Parameters:
DEPTH, 4, long-latency FIFO entries (power of two, >=2)
DATA_W, 32, result data width
REG_AW, 5, register index width (2**REG_AW registers)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
alu_valid  in  1  ALU result offered
alu_rd  in  REG_AW  ALU destination
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU result accepted this cycle (combinational)
lq_valid  in  1  long-latency result offered
lq_rd  in  REG_AW  its destination
lq_data  in  DATA_W  its result
lq_ready  out  1  FIFO not full (combinational)
regWrite  out  1  register file write enable (registered)
writeReg  out  REG_AW  register file write index (registered)
writeData  out  DATA_W  register file write data (registered)
pending  out  2**REG_AW  bit r set while any valid FIFO entry targets r (combinational from FIFO state)

Behaviour:
Reset and enqueue:
- Reset (async assert, sync release): FIFO empty, count 0, regWrite=0, writeReg=0, writeData=0, pending=0.
- Enqueue: lq_valid && lq_ready pushes {lq_rd, lq_data}.
- lq_rd==0 is accepted (lq_ready still governs) but not stored.
- lq_ready = (count != DEPTH).

Per-cycle write selection, registered onto regWrite/writeReg/writeData at the next posedge (latency 1):
1. FIFO full (count==DEPTH) and non-empty: pop head; alu_ready=0.
2. Else if alu_valid and pending[alu_rd]==0: alu_ready=1; write the ALU result. alu_rd==0 gives alu_ready=1 and regWrite=0.
3. Else if FIFO non-empty: pop head; alu_ready=0 if alu_valid (WAW ordering: FIFO results are older).
4. Else regWrite=0.

Boundary rules:
- alu_ready=0 whenever pending[alu_rd]=1 and alu_rd!=0.
- Push and pop in the same cycle: count unchanged; push allowed when full only if a pop occurs that cycle. lq_ready still reads 0 when full, so no same-cycle refill.
- Pointers wrap modulo DEPTH; count is REG_AW-independent, width clog2(DEPTH)+1.
- pending clears for a register when its last FIFO entry pops, i.e. the same cycle regWrite for it is registered.
- Reset mid-operation discards all buffered entries; no write is issued.
- The registered write occurs at the posedge following selection. The register file commits it one edge later.

Optional Feature:
WB_FORWARD_EN:
- Defined: adds ports fwd_reg (in, REG_AW), fwd_hit (out, 1), fwd_data (out, DATA_W).
- fwd_hit = regWrite && writeReg==fwd_reg && fwd_reg!=0; fwd_data = writeData when hit, else 0. Combinational.
- Covers the one-cycle window before the register file commits.
- Undefined: ports absent, no forwarding logic.

Decomposition:
- Shared package cpu_pkg: REG_AW and DATA_W constants, the ZERO_REG constant (0), and the typedef wb_entry_t {rd, data}.
- One sub-module: wb_fifo, a parameterised synchronous FIFO providing push, pop, full, empty, count and an entry-valid/rd view for pending generation.
- Arbitration and output registers stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 FIFO entries -> regWrite=0, pending=0, lq_ready=1 immediately; no writes after release.
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF -> alu_ready=1; next cycle regWrite=1, writeReg=5, writeData=0xDEADBEEF.
- WAW stall: push lq rd=7 data=0x11 while alu_valid with rd=7 data=0x22 -> alu_ready=0 and pending[7]=1; writes occur in order 0x11 then 0x22 to r7; pending[7] clears.
- Full priority: fill FIFO with 4 entries (rd=1..4) while alu_valid with rd=9 -> lq_ready=0, FIFO head drains first with alu_ready=0; r9 written after count<DEPTH; no entry lost.
- r0 handling: lq_rd=0 and alu_rd=0 offered -> both accepted, regWrite never 1, pending[0] stays 0.
- WB_FORWARD_EN: fwd_reg=5 during the cycle regWrite=1, writeReg=5, writeData=0x1234 -> fwd_hit=1, fwd_data=0x1234; fwd_reg=0 gives fwd_hit=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file writeback constants and types.
// Holds the default widths, the hard-wired zero register and the result entry.
package cpu_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order buffer of long-latency results awaiting writeback.
// Ports: clk, rst_n, push/pushEntry, pop/headEntry, full, empty, count,
//   entryValid/entryRd (per-slot view used to build the pending mask).
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  wb_entry_t                    pushEntry,
  input  logic                         pop,
  output wb_entry_t                    headEntry,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic [DEPTH-1:0]             entryValid,
  output logic [DEPTH-1:0][REG_AW-1:0] entryRd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic doPush;
  logic doPop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A push into a full buffer is only legal when the head leaves.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  assign headEntry = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushEntry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      unique case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Slot i is live when its distance from the head is below count.
  always_comb begin
    entryValid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entryRd[i]    = mem[i].rd;
      entryValid[i] = ({1'b0, PW'(i) - rdPtr}) < count;
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: merges ALU and long-latency results onto the
// register file write port (regWrite/writeReg/writeData, registered).
// Ports: clk, rst_n; alu_valid/alu_rd/alu_data/alu_ready;
//   lq_valid/lq_rd/lq_data/lq_ready; regWrite/writeReg/writeData; pending.
// Optional WB_FORWARD_EN macro adds fwd_reg/fwd_hit/fwd_data.
module regfile_writeback_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [REG_AW-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 lq_valid,
  input  logic [REG_AW-1:0]    lq_rd,
  input  logic [DATA_W-1:0]    lq_data,
  output logic                 lq_ready,
  output logic                 regWrite,
  output logic [REG_AW-1:0]    writeReg,
  output logic [DATA_W-1:0]    writeData,
  output logic [2**REG_AW-1:0] pending
`ifdef WB_FORWARD_EN
  ,
  input  logic [REG_AW-1:0]    fwd_reg,
  output logic                 fwd_hit,
  output logic [DATA_W-1:0]    fwd_data
`endif
);

  import cpu_pkg::*;

  wb_entry_t pushEntry;
  wb_entry_t headEntry;
  logic full;
  logic empty;
  logic [$clog2(DEPTH):0] count;
  logic [DEPTH-1:0] entryValid;
  logic [DEPTH-1:0][REG_AW-1:0] entryRd;

  logic push;
  logic aluGo;
  logic selAlu;
  logic selFifo;

  assign lq_ready = (count != ($clog2(DEPTH)+1)'(DEPTH));

  // r0 results are acknowledged but never buffered.
  assign push = lq_valid && lq_ready && (lq_rd != ZERO_REG);

  assign pushEntry = '{rd: lq_rd, data: lq_data};

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (selFifo),
    .headEntry (headEntry),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .entryValid(entryValid),
    .entryRd   (entryRd)
  );

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i]) begin
        pending[entryRd[i]] = 1'b1;
      end
    end
  end

  // An ALU result to a buffered register must wait behind the older one.
  assign aluGo = alu_valid && !pending[alu_rd];

  always_comb begin
    selAlu  = 1'b0;
    selFifo = 1'b0;
    unique case (1'b1)
      full:                    selFifo = 1'b1;
      !full && aluGo:          selAlu  = 1'b1;
      !full && !aluGo && !empty: selFifo = 1'b1;
      default: ;
    endcase
  end

  assign alu_ready = selAlu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else begin
      regWrite <= 1'b0;
      if (selAlu && alu_rd != ZERO_REG) begin
        regWrite  <= 1'b1;
        writeReg  <= alu_rd;
        writeData <= alu_data;
      end else if (selFifo) begin
        regWrite  <= 1'b1;
        writeReg  <= headEntry.rd;
        writeData <= headEntry.data;
      end
    end
  end

`ifdef WB_FORWARD_EN
  // Bridges the edge between registering a write and the file committing it.
  assign fwd_hit  = regWrite && writeReg == fwd_reg && fwd_reg != ZERO_REG;
  assign fwd_data = fwd_hit ? writeData : '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb_regfile_writeback_arbiter: directed and random stimulus against a
// queue-based reference of the writeback arbitration rules.
module tb_regfile_writeback_arbiter;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lq_valid;
  logic [4:0]  lq_rd;
  logic [31:0] lq_data;
  logic        lq_ready;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [31:0] pending;
`ifdef WB_FORWARD_EN
  logic [4:0]  fwd_reg;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int nChecks = 0;
  int nPass   = 0;

  ent_t q[$];

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_valid(alu_valid),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .alu_ready(alu_ready),
    .lq_valid (lq_valid),
    .lq_rd    (lq_rd),
    .lq_data  (lq_data),
    .lq_ready (lq_ready),
    .regWrite (regWrite),
    .writeReg (writeReg),
    .writeData(writeData),
    .pending  (pending)
`ifdef WB_FORWARD_EN
    ,
    .fwd_reg  (fwd_reg),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idleInputs();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    lq_valid  = 1'b0;
    lq_rd     = '0;
    lq_data   = '0;
  endtask

  // One clock of stimulus; the model applies the priority rules directly
  // to the queue of buffered results.
  task automatic step(input logic av, input logic [4:0] ard,
                      input logic [31:0] ad, input logic lv,
                      input logic [4:0] lrd, input logic [31:0] ld);
    logic [31:0] pend;
    logic        isFull;
    logic        aluOk;
    logic        nRW;
    logic [4:0]  nWR;
    logic [31:0] nWD;
    ent_t        e;
    @(negedge clk);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    lq_valid  = lv;
    lq_rd     = lrd;
    lq_data   = ld;
    #1;
    pend = '0;
    foreach (q[i]) pend[q[i].rd] = 1'b1;
    isFull = (q.size() == DEPTH);
    aluOk  = av && !pend[ard];
    check("lq_ready", lq_ready, !isFull);
    check("alu_ready", alu_ready, !isFull && aluOk);
    check("pending", pending, pend);
    nRW = 1'b0;
    nWR = '0;
    nWD = '0;
    if (isFull) begin
      e = q.pop_front();
      nRW = 1'b1; nWR = e.rd; nWD = e.data;
    end else if (aluOk) begin
      if (ard != 0) begin
        nRW = 1'b1; nWR = ard; nWD = ad;
      end
    end else if (q.size() > 0) begin
      e = q.pop_front();
      nRW = 1'b1; nWR = e.rd; nWD = e.data;
    end
    if (lv && !isFull && lrd != 0) begin
      e.rd = lrd;
      e.data = ld;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    check("regWrite", regWrite, nRW);
    if (nRW) begin
      check("writeReg", writeReg, nWR);
      check("writeData", writeData, nWD);
    end
`ifdef WB_FORWARD_EN
    check("fwd_hit", fwd_hit, nRW && nWR == fwd_reg && fwd_reg != 0);
    check("fwd_data", fwd_data,
          (nRW && nWR == fwd_reg && fwd_reg != 0) ? nWD : 32'h0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    idleInputs();
`ifdef WB_FORWARD_EN
    fwd_reg = 5'd5;
`endif
    repeat (2) @(negedge clk);
    check("rst regWrite", regWrite, 0);
    check("rst writeReg", writeReg, 0);
    check("rst writeData", writeData, 0);
    check("rst pending", pending, 0);
    check("rst lq_ready", lq_ready, 1);
    rst_n = 1'b1;

    // ALU only
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // WAW: buffered r7 must be written before the ALU r7
    step(0, 0, 0, 1, 5'd7, 32'h11);
    step(1, 5'd7, 32'h22, 0, 0, 0);
    step(1, 5'd7, 32'h22, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Full priority: ALU keeps winning until the buffer fills
    for (int i = 0; i < 8; i++)
      step(1, 5'd9, 32'h900 + i, 1, 5'(i % 4 + 1), 32'h100 + i);
    repeat (6) step(0, 0, 0, 0, 0, 0);

    // r0 on both sides
    step(1, 5'd0, 32'hAAAA, 1, 5'd0, 32'hBBBB);
    step(0, 0, 0, 0, 0, 0);

`ifdef WB_FORWARD_EN
    fwd_reg = 5'd5;
    step(1, 5'd5, 32'h1234, 0, 0, 0);
    fwd_reg = 5'd0;
    step(1, 5'd0, 32'h1234, 0, 0, 0);
`endif

    // Random traffic over a small register range to provoke collisions
    for (int i = 0; i < 400; i++) begin
`ifdef WB_FORWARD_EN
      fwd_reg = 5'($urandom_range(0, 7));
`endif
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
           $urandom);
    end
    repeat (6) step(0, 0, 0, 0, 0, 0);

    // Reset with two buffered entries
    step(1, 5'd3, 32'h33, 1, 5'd10, 32'hA0);
    step(1, 5'd3, 32'h34, 1, 5'd11, 32'hB0);
    @(negedge clk);
    idleInputs();
    rst_n = 1'b0;
    #1;
    check("mid rst regWrite", regWrite, 0);
    check("mid rst pending", pending, 0);
    check("mid rst lq_ready", lq_ready, 1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
